sdrc_bram_responder: RTL and testbench

//   Responder for the SDRAM controller user interface (cmd_en/cmd/addr/data_len/data/dqm -> cmd_ack/data/init_done),

---
 rtl/sdrc_bram_responder_if.sv | 29 ++
 rtl/sdrc_bram_responder.sv | 118 +++++++++++
 tb/tb_sdrc_bram_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdrc_bram_responder_if.sv
// sdrc_bram_responder_if: SDRAM-controller user-interface bundle between a cache-side master and the BRAM responder
// master -> slave: I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
//                  I_sdrc_addr {bank,row,col}, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len
// slave -> master: O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, O_protocol_err
interface sdrc_bram_responder_if;
    logic        I_sdrc_cmd_en;
    logic [2:0]  I_sdrc_cmd;
    logic        I_sdrc_precharge_ctrl;
    logic        I_sdram_power_down;
    logic        I_sdram_selfrefresh;
    logic [20:0] I_sdrc_addr;
    logic [3:0]  I_sdrc_dqm;
    logic [31:0] I_sdrc_data;
    logic [7:0]  I_sdrc_data_len;
    logic [31:0] O_sdrc_data;
    logic        O_sdrc_init_done;
    logic        O_sdrc_cmd_ack;
    logic        O_protocol_err;
    modport master (
        output I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
               I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
        input  O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, O_protocol_err
    );
    modport slave (
        input  I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
               I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
        output O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, O_protocol_err
    );
endinterface

// File: rtl/sdrc_bram_responder.sv
// sdrc_bram_responder: block-RAM stand-in for the SDRAM controller + SDRAM behind the cache
// clk, rst (sync, active high); bus: slave side of sdrc_bram_responder_if (commands/write data in,
// read data, init_done, cmd_ack and sticky protocol_err out)
module sdrc_bram_responder #(
    parameter int RAM_ADDRESS_BIT_WIDTH = 12,
    parameter int INIT_CYCLES           = 16,
    parameter int ACT_ACK_DELAY         = 1,
    parameter int WR_ACK_DELAY          = 3,
    parameter int RD_LATENCY            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    sdrc_bram_responder_if.slave        bus
);
    localparam int          AW        = RAM_ADDRESS_BIT_WIDTH;
    localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] ACT_D     = 16'(ACT_ACK_DELAY);
    localparam logic [15:0] WR_D      = 16'(WR_ACK_DELAY);
    localparam logic [15:0] RD_L      = 16'(RD_LATENCY);

    typedef enum logic [2:0] {INIT, IDLE, ACK_WAIT, WRITE, READ} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem [2**AW];
    logic [15:0]   cyc, cyc_nxt, ack_at, end_at, ack_at_in, rd_k;
    logic [1:0]    bank, in_bank;
    logic [10:0]   row;
    logic [10:0]   open_row [4];
    logic [7:0]    col, len;
    logic [3:0]    bank_open;
    logic          ok, pre, done, ack, err;
    logic          take, busy, wr_cmd, rd_cmd, ack_nxt, close, wr_en, rd_en;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [31:0]   rdata;

    // cyc is the index of the current cycle relative to the accepted command (cycle 0 = cmd_en cycle),
    // and counts init cycles while in INIT
    always_comb begin
        in_bank   = bus.I_sdrc_addr[20:19];
        wr_cmd    = bus.I_sdrc_cmd == 3'b100;
        rd_cmd    = bus.I_sdrc_cmd == 3'b101;
        busy      = state inside {ACK_WAIT, WRITE, READ};
        take      = state == IDLE && bus.I_sdrc_cmd_en && !bus.I_sdram_power_down && !bus.I_sdram_selfrefresh;
        ack_at_in = wr_cmd ? {8'd0, bus.I_sdrc_data_len} + WR_D : rd_cmd ? RD_L : ACT_D;
        // ack is registered, so it is raised on the edge before its cycle
        ack_nxt   = take ? (ack_at_in == 16'd1) : (busy && cyc + 16'd1 == ack_at);
        close     = ack_nxt && (take ? bus.I_sdrc_precharge_ctrl && (wr_cmd || rd_cmd) : pre);
        state_nxt = state == INIT ? (cyc == INIT_LAST ? IDLE : INIT)
                  : take ? (wr_cmd ? WRITE : rd_cmd ? READ : ACK_WAIT)
                  : (busy && cyc == end_at) ? IDLE : state;
        cyc_nxt   = take ? 16'd1 : (state == INIT || busy) ? cyc + 16'd1 : 16'd0;
        // word 0 of a write is stored on the accepting edge itself, using the row open at that moment
        wr_en     = take ? wr_cmd && bank_open[in_bank] : state == WRITE && ok && cyc <= {8'd0, len};
        wr_idx    = take ? AW'({in_bank, open_row[in_bank], bus.I_sdrc_addr[7:0]})
                         : AW'({bank, row, col + cyc[7:0]});
        // word k is fetched on the edge ending cycle RD_LATENCY-1+k
        rd_k      = cyc - (RD_L - 16'd1);
        rd_en     = state == READ && cyc >= RD_L - 16'd1 && rd_k <= {8'd0, len};
        rd_idx    = AW'({bank, row, col + rd_k[7:0]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cyc       <= '0;
            bank_open <= '0;
            done      <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_nxt;
            ack   <= ack_nxt;
            if (state == INIT && cyc == INIT_LAST)
                done <= 1'b1;
            if ((bus.I_sdrc_cmd_en && !take) || (take && (wr_cmd || rd_cmd) && !bank_open[in_bank]))
                err <= 1'b1;
            if (take) begin
                bank   <= in_bank;
                row    <= open_row[in_bank];
                col    <= bus.I_sdrc_addr[7:0];
                len    <= bus.I_sdrc_data_len;
                ok     <= bank_open[in_bank];
                pre    <= bus.I_sdrc_precharge_ctrl && (wr_cmd || rd_cmd);
                ack_at <= ack_at_in;
                end_at <= rd_cmd ? RD_L + {8'd0, bus.I_sdrc_data_len} : ack_at_in;
            end
            if (take && bus.I_sdrc_cmd == 3'b011) begin
                bank_open[in_bank] <= 1'b1;
                open_row[in_bank]  <= bus.I_sdrc_addr[18:8];
            end
            if (take && bus.I_sdrc_cmd == 3'b010)
                bank_open <= '0;
            if (close)
                bank_open[take ? in_bank : bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (rd_en)
            rdata <= ok ? mem[rd_idx] : '0;
    end

    // RAM has no reset so its contents survive rst
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            for (int b = 0; b < 4; b++)
                if (!bus.I_sdrc_dqm[b])
                    mem[wr_idx][8*b +: 8] <= bus.I_sdrc_data[8*b +: 8];
    end

    assign bus.O_sdrc_data      = rdata;
    assign bus.O_sdrc_init_done = done;
    assign bus.O_sdrc_cmd_ack   = ack;
    assign bus.O_protocol_err   = err;
endmodule

// File: tb/tb_sdrc_bram_responder.sv
// tb_sdrc_bram_responder: directed bench with a cycle-indexed behavioural model of the BRAM responder
module tb_sdrc_bram_responder;
    localparam int AW = 12, IC = 16, AD = 1, WD = 3, RL = 4, N = 2048;
    localparam logic [2:0] OP_PRE = 3'b010, OP_ACT = 3'b011, OP_WR = 3'b100, OP_RD = 3'b101;

    logic clk = 1'b0, rst = 1'b1, chk = 1'b0;
    int   cyc = 0, checks = 0, errors = 0;
    int   idle_from, done_from, err_from;
    bit          m_open [4];
    logic [10:0] m_row [4];
    logic [31:0] m_mem [int];
    logic [31:0] exp_data [N];
    bit          exp_ack [N];
    logic [31:0] wd [16];
    logic [3:0]  wm [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdrc_bram_responder_if bus();
    sdrc_bram_responder #(.RAM_ADDRESS_BIT_WIDTH(AW), .INIT_CYCLES(IC), .ACT_ACK_DELAY(AD),
                          .WR_ACK_DELAY(WD), .RD_LATENCY(RL))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk)
        if (chk && cyc < N) begin
            lit("ack", {31'd0, bus.O_sdrc_cmd_ack}, {31'd0, exp_ack[cyc]});
            lit("data", bus.O_sdrc_data, exp_data[cyc]);
            lit("init_done", {31'd0, bus.O_sdrc_init_done}, {31'd0, cyc >= done_from});
            lit("protocol_err", {31'd0, bus.O_protocol_err}, {31'd0, cyc >= err_from});
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int key(int b, logic [10:0] r, logic [7:0] c);
        return int'({b[1:0], r, c}) % (1 << AW);
    endfunction

    task automatic set_ack(input int c, input int idle);
        if (c < N) exp_ack[c] = 1'b1;
        idle_from = idle;
    endtask

    // spec-level effect of a command presented on cycle t
    task automatic model(input logic [2:0] op, input logic [20:0] a, input int len, input logic pre, input int t);
        int b;
        int k2;
        logic [31:0] old, v;
        b = int'(a[20:19]);
        if (t < idle_from || t < done_from || bus.I_sdram_power_down || bus.I_sdram_selfrefresh) begin
            if (t + 1 < err_from) err_from = t + 1;
            return;
        end
        if ((op == OP_WR || op == OP_RD) && !m_open[b] && t + 1 < err_from) err_from = t + 1;
        if (op == OP_ACT) begin
            m_open[b] = 1'b1;
            m_row[b] = a[18:8];
            set_ack(t + AD, t + AD + 1);
        end else if (op == OP_PRE) begin
            for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
            set_ack(t + AD, t + AD + 1);
        end else if (op == OP_WR) begin
            if (m_open[b])
                for (int k = 0; k <= len; k++) begin
                    k2 = key(b, m_row[b], 8'(a[7:0] + k));
                    old = m_mem.exists(k2) ? m_mem[k2] : 32'd0;
                    for (int y = 0; y < 4; y++)
                        v[8*y +: 8] = wm[k][y] ? old[8*y +: 8] : wd[k][8*y +: 8];
                    m_mem[k2] = v;
                end
            set_ack(t + len + WD, t + len + WD + 1);
        end else if (op == OP_RD) begin
            v = 32'd0;
            for (int k = 0; k <= len; k++) begin
                v = m_open[b] ? m_mem[key(b, m_row[b], 8'(a[7:0] + k))] : 32'd0;
                if (t + RL + k < N) exp_data[t + RL + k] = v;
            end
            for (int c = t + RL + len + 1; c < N; c++) exp_data[c] = v;
            set_ack(t + RL, t + RL + len + 1);
        end else
            set_ack(t + AD, t + AD + 1);
        if (pre && (op == OP_WR || op == OP_RD)) m_open[b] = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [20:0] a, input int len, input logic pre = 1'b0);
        model(op, a, len, pre, cyc);
        bus.I_sdrc_cmd_en = 1'b1;
        bus.I_sdrc_cmd = op;
        bus.I_sdrc_addr = a;
        bus.I_sdrc_data_len = 8'(len);
        bus.I_sdrc_precharge_ctrl = pre;
        bus.I_sdrc_data = wd[0];
        bus.I_sdrc_dqm = wm[0];
        step();
        bus.I_sdrc_cmd_en = 1'b0;
        bus.I_sdrc_precharge_ctrl = 1'b0;
        if (op == OP_WR)
            for (int k = 1; k <= len; k++) begin
                bus.I_sdrc_data = wd[k];
                bus.I_sdrc_dqm = wm[k];
                step();
            end
        bus.I_sdrc_data = '0;
        bus.I_sdrc_dqm = '0;
    endtask

    task automatic wait_idle();
        while (cyc < idle_from) step();
    endtask

    task automatic do_reset();
        int n;
        chk = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
        for (int c = cyc; c < N; c++) begin
            exp_ack[c] = 1'b0;
            exp_data[c] = '0;
        end
        done_from = cyc + IC;
        idle_from = done_from;
        err_from = N + 1;
        chk = 1'b1;
        lit("reset_init_done", {31'd0, bus.O_sdrc_init_done}, 32'd0);
        n = 0;
        while (!bus.O_sdrc_init_done && n < 40) begin
            step();
            n++;
        end
        lit("init_latency", n, IC);
    endtask

    task automatic load(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        wd[0] = a0; wd[1] = a1; wd[2] = a2; wd[3] = a3;
        wd[4] = a4; wd[5] = a5; wd[6] = a6; wd[7] = a7;
        for (int i = 0; i < 16; i++) wm[i] = 4'b0000;
    endtask

    initial begin
        logic [31:0] r1 [4];
        r1 = '{32'h1010_2020, 32'habcd_ef01, 32'h5678_1010, 32'habcd_fefe};
        bus.I_sdrc_cmd_en = 1'b0;
        bus.I_sdrc_cmd = '0;
        bus.I_sdrc_precharge_ctrl = 1'b0;
        bus.I_sdram_power_down = 1'b0;
        bus.I_sdram_selfrefresh = 1'b0;
        bus.I_sdrc_addr = '0;
        bus.I_sdrc_dqm = '0;
        bus.I_sdrc_data = '0;
        bus.I_sdrc_data_len = '0;
        load('0, '0, '0, '0, '0, '0, '0, '0);
        do_reset();

        cmd(OP_ACT, 21'h000000, 0);
        lit("act_ack", {31'd0, bus.O_sdrc_cmd_ack}, 32'd1);
        wait_idle();
        load(32'h1234_5678, 32'habcd_ef01, 32'h8765_4321, 32'habcd_ef02,
             32'h0f0f_0f0f, 32'habcd_ef03, 32'hf0f0_f0f0, 32'habcd_ef04);
        cmd(OP_WR, 21'h000000, 7);
        step();
        step();
        lit("wr_ack", {31'd0, bus.O_sdrc_cmd_ack}, 32'd1);
        wait_idle();

        cmd(OP_ACT, 21'h000100, 0);
        wait_idle();
        load(32'h1010_2020, 32'habcd_ef01, 32'h5678_1010, 32'habcd_fefe,
             32'h3030_4040, 32'h5050_6060, 32'h7070_8080, 32'h9090_a0a0);
        cmd(OP_WR, 21'h000000, 7);
        wait_idle();
        cmd(OP_ACT, 21'h000000, 0);
        wait_idle();
        cmd(OP_RD, 21'h000000, 7);
        repeat (3) step();
        lit("rd_word0", bus.O_sdrc_data, 32'h1234_5678);
        lit("rd_ack", {31'd0, bus.O_sdrc_cmd_ack}, 32'd1);
        wait_idle();

        cmd(OP_ACT, 21'h000100, 0);
        wait_idle();
        cmd(OP_RD, 21'h000000, 3);
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            lit("row1_word", bus.O_sdrc_data, r1[k]);
            step();
        end
        wait_idle();

        load(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, '0, '0, '0, '0);
        cmd(OP_WR, 21'h0000fc, 3);
        wait_idle();
        load(32'ha0a0_a0a1, 32'hbeef_cafe, 32'hc0c0_c0c2, 32'hd0d0_d0d3, '0, '0, '0, '0);
        wm[1] = 4'b0011;
        cmd(OP_WR, 21'h0000fe, 3);
        wm[1] = 4'b0000;
        wait_idle();
        cmd(OP_RD, 21'h0000fc, 7);
        repeat (6) step();
        lit("masked_word", bus.O_sdrc_data, 32'hbeef_4444);
        step();
        lit("wrapped_word", bus.O_sdrc_data, 32'hc0c0_c0c2);
        wait_idle();

        lit("err_clean", {31'd0, bus.O_protocol_err}, 32'd0);
        cmd(OP_PRE, 21'h000000, 0);
        wait_idle();
        cmd(OP_RD, 21'h000000, 1);
        wait_idle();
        lit("closed_rd_data", bus.O_sdrc_data, 32'd0);
        lit("closed_rd_err", {31'd0, bus.O_protocol_err}, 32'd1);

        do_reset();
        cmd(OP_ACT, 21'h000000, 0);
        wait_idle();
        cmd(OP_RD, 21'h000000, 7, 1'b1);
        cmd(OP_RD, 21'h000100, 0);
        wait_idle();
        lit("busy_err", {31'd0, bus.O_protocol_err}, 32'd1);
        cmd(OP_RD, 21'h000000, 0);
        wait_idle();
        lit("autopre_rd_data", bus.O_sdrc_data, 32'd0);

        do_reset();
        bus.I_sdram_power_down = 1'b1;
        cmd(OP_ACT, 21'h000000, 0);
        bus.I_sdram_power_down = 1'b0;
        repeat (3) step();
        lit("pd_err", {31'd0, bus.O_protocol_err}, 32'd1);
        do_reset();
        lit("err_after_rst", {31'd0, bus.O_protocol_err}, 32'd0);
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
